// File: rtl/finish_ctrl.sv
// Game-over controller: KO detection, freeze/slide/hold/wait sequencing and banner overlay.
// Optional blinking banner in SHOW/WAIT is enabled by defining BANNER_BLINK_EN.
module finish_ctrl #(
  parameter int          HP_W        = 7,
  parameter int          BANNER_X    = 160,
  parameter int          BANNER_Y    = 206,
  parameter int          SLIDE_STEP  = 4,
  parameter int          KO_FRAMES   = 60,
  parameter int          HOLD_FRAMES = 120,
  parameter logic [11:0] KEY_COLOR   = 12'hF0F
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            frame_tick,
  input  logic [9:0]      hcount,
  input  logic [9:0]      vcount,
  input  logic            video_on,
  input  logic [11:0]     game_pixel,
  input  logic [HP_W-1:0] p1_health,
  input  logic [HP_W-1:0] p2_health,
  input  logic            start_btn,
  input  logic [11:0]     banner_pixel,
  output logic [14:0]     rom_addr,
  output logic [2:0]      finish,
  output logic [11:0]     pixel_out,
  output logic            game_over,
  output logic            restart_req
);

  localparam int BANNER_W = 320;
  localparam int BANNER_H = 67;

  localparam logic [2:0] ST_PLAY  = 3'd0;
  localparam logic [2:0] ST_KO    = 3'd1;
  localparam logic [2:0] ST_SLIDE = 3'd2;
  localparam logic [2:0] ST_SHOW  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

  localparam logic signed [10:0] YPOS_START = -$signed(11'(BANNER_H));
  localparam logic signed [10:0] YPOS_FINAL = $signed(11'(BANNER_Y));
  localparam logic signed [10:0] YPOS_STEP  = $signed(11'(SLIDE_STEP));
  localparam logic [7:0]         KO_LAST    = 8'(KO_FRAMES - 1);
  localparam logic [7:0]         HOLD_LAST  = 8'(HOLD_FRAMES - 1);

  logic [2:0]         state_q, state_d;
  logic               p2_wins_q, p2_wins_d;
  logic signed [10:0] ypos_q, ypos_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic               restart_q, restart_d;
  logic               start_prev_q;

  logic               p1_zero, p2_zero, start_rise;
  logic signed [10:0] ypos_step;
  logic               banner_vis;

  assign p1_zero    = (p1_health == '0);
  assign p2_zero    = (p2_health == '0);
  assign start_rise = start_btn & ~start_prev_q;
  assign ypos_step  = ypos_q + YPOS_STEP;

  always_comb begin
    state_d     = state_q;
    p2_wins_d   = p2_wins_q;
    ypos_d      = ypos_q;
    frame_cnt_d = frame_cnt_q;
    restart_d   = 1'b0;
    case (state_q)
      ST_PLAY: begin
        if (p1_zero || p2_zero) begin
          state_d     = ST_KO;
          p2_wins_d   = p1_zero & ~p2_zero;
          frame_cnt_d = '0;
        end
      end
      ST_KO: begin
        if (frame_tick) begin
          if (frame_cnt_q == KO_LAST) begin
            state_d     = ST_SLIDE;
            frame_cnt_d = '0;
            ypos_d      = YPOS_START;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      ST_SLIDE: begin
        if (frame_tick) begin
          if (ypos_step >= YPOS_FINAL) begin
            ypos_d      = YPOS_FINAL;
            state_d     = ST_SHOW;
            frame_cnt_d = '0;
          end else begin
            ypos_d = ypos_step;
          end
        end
      end
      ST_SHOW: begin
        if (frame_tick) begin
          if (frame_cnt_q == HOLD_LAST) begin
            state_d     = ST_WAIT;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      ST_WAIT: begin
        // A level still held from SHOW has start_prev_q=1, so only a fresh press restarts.
        if (start_rise) begin
          state_d   = ST_PLAY;
          restart_d = 1'b1;
          p2_wins_d = 1'b0;
          ypos_d    = YPOS_START;
        end
      end
      default: state_d = ST_PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_l) begin
      state_q      <= ST_PLAY;
      p2_wins_q    <= 1'b0;
      ypos_q       <= YPOS_START;
      frame_cnt_q  <= '0;
      restart_q    <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      p2_wins_q    <= p2_wins_d;
      ypos_q       <= ypos_d;
      frame_cnt_q  <= frame_cnt_d;
      restart_q    <= restart_d;
      start_prev_q <= start_btn;
    end
  end

`ifdef BANNER_BLINK_EN
  logic       vis_q, vis_d;
  logic [4:0] blink_cnt_q, blink_cnt_d;

  always_comb begin
    vis_d       = vis_q;
    blink_cnt_d = blink_cnt_q;
    if (state_q == ST_SLIDE && state_d == ST_SHOW) begin
      vis_d       = 1'b1;
      blink_cnt_d = '0;
    end else if ((state_q == ST_SHOW || state_q == ST_WAIT) && frame_tick) begin
      if (blink_cnt_q == 5'd29) begin
        blink_cnt_d = '0;
        vis_d       = ~vis_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_l) begin
      vis_q       <= 1'b1;
      blink_cnt_q <= '0;
    end else begin
      vis_q       <= vis_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign banner_vis = (state_q == ST_SLIDE) |
                      ((state_q == ST_SHOW || state_q == ST_WAIT) & vis_q);
`else
  assign banner_vis = (state_q == ST_SLIDE) | (state_q == ST_SHOW) | (state_q == ST_WAIT);
`endif

  assign game_over   = (state_q != ST_PLAY);
  assign finish      = {banner_vis, p2_wins_q, game_over};
  assign restart_req = restart_q;

  // Stage 1: window test and ROM address; rows above the screen never match since vcount >= 0.
  logic signed [11:0] row_off;
  logic [8:0]         col_off;
  logic               in_row, in_col, in_banner_d;
  logic [14:0]        rom_addr_d;

  assign row_off = $signed({2'b00, vcount}) - $signed({ypos_q[10], ypos_q});
  assign col_off = 9'(hcount - 10'(BANNER_X));
  assign in_row  = !row_off[11] && (row_off <= $signed(12'(BANNER_H - 1)));
  assign in_col  = (hcount >= 10'(BANNER_X)) && (hcount <= 10'(BANNER_X + BANNER_W - 1));
  assign in_banner_d = banner_vis & in_row & in_col;

  // row*320 split as row*256 + row*64.
  always_comb begin
    rom_addr_d = '0;
    if (in_banner_d) begin
      rom_addr_d = {row_off[6:0], 8'b0} + {2'b00, row_off[6:0], 6'b0} + {6'b0, col_off};
    end
  end

  logic [14:0] rom_addr_q;
  logic        in_banner_s1_q, video_on_s1_q;
  logic [11:0] game_pixel_s1_q;
  logic        in_banner_s2_q, video_on_s2_q;
  logic [11:0] game_pixel_s2_q;
  logic [11:0] pixel_q, pixel_d;

  // Stage 3 mux: banner_pixel arrives together with the stage-2 copies.
  always_comb begin
    pixel_d = game_pixel_s2_q;
    if (!video_on_s2_q) begin
      pixel_d = '0;
    end else if (in_banner_s2_q && banner_pixel != KEY_COLOR) begin
      pixel_d = banner_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_l) begin
      rom_addr_q      <= '0;
      in_banner_s1_q  <= 1'b0;
      video_on_s1_q   <= 1'b0;
      game_pixel_s1_q <= '0;
      in_banner_s2_q  <= 1'b0;
      video_on_s2_q   <= 1'b0;
      game_pixel_s2_q <= '0;
      pixel_q         <= '0;
    end else begin
      rom_addr_q      <= rom_addr_d;
      in_banner_s1_q  <= in_banner_d;
      video_on_s1_q   <= video_on;
      game_pixel_s1_q <= game_pixel;
      in_banner_s2_q  <= in_banner_s1_q;
      video_on_s2_q   <= video_on_s1_q;
      game_pixel_s2_q <= game_pixel_s1_q;
      pixel_q         <= pixel_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pixel_out = pixel_q;

endmodule

// File: tb/tb_finish_ctrl.sv
// Bench for finish_ctrl: random KO rounds checked against a tick-count model of the game-over sequence.
module tb_finish_ctrl;

  localparam int KO_N     = 60;
  localparam int HOLD_N   = 120;
  localparam int STEP     = 4;
  localparam int FINAL_Y  = 206;
  localparam int BAN_H    = 67;
  localparam int SLIDE_N  = (FINAL_Y + BAN_H + STEP - 1) / STEP;
  localparam int SHOW_AT  = KO_N + SLIDE_N;
  localparam int WAIT_AT  = SHOW_AT + HOLD_N;
  localparam logic [11:0] KEY = 12'hF0F;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        frame_tick;
  logic [9:0]  hcount, vcount;
  logic        video_on;
  logic [11:0] game_pixel;
  logic [6:0]  p1_health, p2_health;
  logic        start_btn;
  logic [11:0] banner_pixel;
  logic [14:0] rom_addr;
  logic [2:0]  finish;
  logic [11:0] pixel_out;
  logic        game_over;
  logic        restart_req;

  int tests = 0;
  int fails = 0;

  finish_ctrl dut (
    .clk(clk), .rst_l(rst_l), .frame_tick(frame_tick), .hcount(hcount), .vcount(vcount),
    .video_on(video_on), .game_pixel(game_pixel), .p1_health(p1_health), .p2_health(p2_health),
    .start_btn(start_btn), .banner_pixel(banner_pixel), .rom_addr(rom_addr), .finish(finish),
    .pixel_out(pixel_out), .game_over(game_over), .restart_req(restart_req)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Banner visibility as a function of frame ticks since KO.
  function automatic logic m_vis(input int k);
    if (k < KO_N) return 1'b0;
    if (k < SHOW_AT) return 1'b1;
`ifdef BANNER_BLINK_EN
    return (((k - SHOW_AT) / 30) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int m_ypos(input int k);
    int y;
    if (k < KO_N) return -BAN_H;
    y = -BAN_H + STEP * (k - KO_N);
    return (y > FINAL_Y) ? FINAL_Y : y;
  endfunction

  function automatic logic [2:0] m_finish(input int k, input logic p2);
    return {m_vis(k), p2, 1'b1};
  endfunction

  function automatic logic [11:0] rom_func(input logic [14:0] a);
    if (int'(a) % 5 == 0) return KEY;
    return 12'((int'(a) * 37 + 291) % 4096);
  endfunction

  // Stream pixels through the 3-stage pipeline while the FSM is frozen; the bench acts as the ROM.
  task automatic stream(input logic vis, input int y, input int n);
    logic [14:0] ea [0:31];
    logic [11:0] ep [0:31];
    logic [14:0] addr_prev;
    logic [14:0] a;
    logic [11:0] gp, bp;
    logic        vo, inb;
    int h, v, row;
    addr_prev = '0;
    for (int j = 0; j < n + 3; j++) begin
      if (j >= 1) check("rom_addr", 32'(rom_addr), 32'(ea[j-1]));
      if (j >= 3) check("pixel_out", 32'(pixel_out), 32'(ep[j-3]));
      banner_pixel = rom_func(addr_prev);
      addr_prev = rom_addr;
      if (j < n) begin
        case (j)
          0: begin h = 160; v = y; end
          1: begin h = 479; v = y + 66; end
          2: begin h = 480; v = y + 5; end
          default: begin
            h = int'($urandom_range(100, 540));
            v = y - 8 + int'($urandom_range(0, 82));
          end
        endcase
        if (v < 0) v = 0;
        if (v > 479) v = 479;
        vo  = (j < 3) ? 1'b1 : ($urandom_range(0, 7) != 0);
        gp  = 12'($urandom);
        row = v - y;
        inb = vis && h >= 160 && h <= 479 && row >= 0 && row <= 66;
        a   = inb ? 15'(row * 320 + h - 160) : 15'd0;
        bp  = rom_func(a);
        ea[j] = a;
        ep[j] = !vo ? 12'h000 : ((inb && bp != KEY) ? bp : gp);
        hcount = 10'(h); vcount = 10'(v); video_on = vo; game_pixel = gp;
      end else begin
        hcount = '0; vcount = '0; video_on = 1'b0; game_pixel = '0;
      end
      step();
    end
  endtask

  initial begin
    int  ko_type, k;
    logic exp_p2, aborted;
    rst_l = 1'b1; frame_tick = 1'b0; hcount = '0; vcount = '0; video_on = 1'b0;
    game_pixel = '0; p1_health = 7'd50; p2_health = 7'd50; start_btn = 1'b0; banner_pixel = '0;
    step(); step();
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_pixel_out", 32'(pixel_out), 32'd0);
    check("rst_restart", 32'(restart_req), 32'd0);
    rst_l = 1'b0;

    for (int r = 0; r < 4; r++) begin
      ko_type = (r < 3) ? r : int'($urandom_range(0, 2));
      p1_health = 7'($urandom_range(1, 127));
      p2_health = 7'($urandom_range(1, 127));
      repeat (5) begin
        frame_tick = 1'($urandom_range(0, 1));
        step();
        frame_tick = 1'b0;
        check("play_finish", 32'(finish), 32'd0);
        check("play_restart", 32'(restart_req), 32'd0);
      end
      stream(1'b0, -BAN_H, 12);

      case (ko_type)
        0: p2_health = '0;
        1: p1_health = '0;
        default: begin p1_health = '0; p2_health = '0; end
      endcase
      exp_p2 = (ko_type == 1);
      step();
      check("ko_game_over", 32'(game_over), 32'd1);
      check("ko_finish", 32'(finish), 32'({1'b0, exp_p2, 1'b1}));
      p1_health = 7'($urandom_range(0, 127));
      p2_health = 7'($urandom_range(0, 127));

      k = 0;
      aborted = 1'b0;
      while (k < WAIT_AT) begin
        repeat ($urandom_range(0, 2)) step();
        if (r == 3 && k == KO_N + 20) begin
          p1_health = 7'd90; p2_health = 7'd90;
          rst_l = 1'b1;
          step();
          check("midrst_finish", 32'(finish), 32'd0);
          check("midrst_game_over", 32'(game_over), 32'd0);
          check("midrst_rom_addr", 32'(rom_addr), 32'd0);
          check("midrst_pixel_out", 32'(pixel_out), 32'd0);
          check("midrst_restart", 32'(restart_req), 32'd0);
          rst_l = 1'b0;
          step();
          check("midrst_play", 32'(finish), 32'd0);
          aborted = 1'b1;
          break;
        end
        if (k == SHOW_AT + 10) begin
          start_btn = 1'b1;
          step();
          check("show_btn_restart", 32'(restart_req), 32'd0);
          start_btn = 1'b0;
          step();
          check("show_btn_restart2", 32'(restart_req), 32'd0);
          check("show_btn_finish", 32'(finish), 32'(m_finish(k, exp_p2)));
        end
        if (k == WAIT_AT - 1) begin
          start_btn = 1'b1;
          step();
        end
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        k++;
        check("tick_finish", 32'(finish), 32'(m_finish(k, exp_p2)));
        check("tick_restart", 32'(restart_req), 32'd0);
        if (k == KO_N + 10 || k == KO_N + 40 || k == SHOW_AT || k == SHOW_AT + 35 || k == WAIT_AT)
          stream(m_vis(k), m_ypos(k), 16);
      end
      if (aborted) continue;

      // In WAIT with start_btn still held from SHOW: no restart until a fresh press.
      p1_health = 7'($urandom_range(1, 127));
      p2_health = 7'($urandom_range(1, 127));
      repeat (3) begin
        step();
        check("wait_held_restart", 32'(restart_req), 32'd0);
        check("wait_held_finish", 32'(finish), 32'(m_finish(WAIT_AT, exp_p2)));
      end
      start_btn = 1'b0;
      step();
      check("wait_rel_restart", 32'(restart_req), 32'd0);
      start_btn = 1'b1;
      step();
      check("restart_pulse", 32'(restart_req), 32'd1);
      check("restart_finish", 32'(finish), 32'd0);
      check("restart_game_over", 32'(game_over), 32'd0);
      start_btn = 1'b0;
      step();
      check("restart_once", 32'(restart_req), 32'd0);
      check("restart_play", 32'(finish), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/finish_ctrl.md
Name: finish_ctrl

Overview:
- Game-over controller and banner compositor. It sits between the VGA timing/game renderer and the winner-banner ROM stage.
- Detects a KO from the player health values and latches the winner. It then sequences freeze, slide-in, hold and wait-for-restart.
- Generates the 15-bit banner ROM address and the 3-bit finish select each pixel. It overlays the returned 12-bit banner pixel onto the game pixel, with pipeline alignment for the ROM's 1-cycle read latency.

Parameters:
HP_W, 7, width of player health inputs
BANNER_X, 160, banner left column (banner is 320 wide, 640-wide screen)
BANNER_Y, 206, banner final top row (banner is 67 tall)
SLIDE_STEP, 4, rows the banner descends per frame during slide-in
KO_FRAMES, 60, frames of freeze between KO and slide-in
HOLD_FRAMES, 120, frames the banner is held before restart is accepted
KEY_COLOR, 12'hF0F, banner pixel value treated as transparent

Ports:
clk  in  1  system/pixel clock
rst_l  in  1  synchronous, active-high reset (1 = reset)
frame_tick  in  1  one-cycle pulse at start of vertical blank
hcount  in  10  current pixel column
vcount  in  10  current pixel row
video_on  in  1  active display region
game_pixel  in  12  RGB444 from game renderer, aligned with hcount/vcount
p1_health  in  HP_W  player 1 health
p2_health  in  HP_W  player 2 health
start_btn  in  1  debounced, synchronized start button level
banner_pixel  in  12  ROM read data, valid 1 cycle after rom_addr
rom_addr  out  15  banner ROM address
finish  out  3  {banner_visible, p2_wins, game_over}
pixel_out  out  12  composited RGB444 (12'h000 when not video_on)
game_over  out  1  high in every state except PLAY
restart_req  out  1  one-cycle pulse requesting a new round

Behaviour:
- Reset (rst_l=1 at a clk edge): state=PLAY; rom_addr=0; finish=3'b000; pixel_out=0; game_over=0; restart_req=0; banner ypos=-67; frame counter=0. Reset in any state aborts immediately.
- FSM states: PLAY, KO, SLIDE, SHOW, WAIT.
- PLAY -> KO when p1_health==0 or p2_health==0. Winner latched that cycle: p2_wins=1 iff p1_health==0 and p2_health!=0. A double KO gives P1 the win (p2_wins=0). The latched winner is held until return to PLAY; later health changes are ignored.
- KO: count frame_ticks. After KO_FRAMES ticks go to SLIDE with ypos=-67 (signed 11-bit).
- SLIDE: each frame_tick, ypos += SLIDE_STEP. When the result is >= BANNER_Y, clamp ypos=BANNER_Y and go to SHOW.
- SHOW: after HOLD_FRAMES ticks go to WAIT.
- WAIT: on a rising edge of start_btn, restart_req=1 for exactly one cycle and the state returns to PLAY.
- start_btn edges in any other state are ignored. The button level held through entry to WAIT is not an edge.
- finish[0]=game_over; finish[1]=latched p2_wins; finish[2]=1 in SLIDE, SHOW and WAIT (subject to the optional blink).
- Pipeline, with T = cycle the hcount/vcount/game_pixel/video_on inputs are presented:
  - T+1: rom_addr and in_banner are registered. in_banner = finish[2] & hcount in [BANNER_X, BANNER_X+319] & vcount in [ypos, ypos+66]. When in_banner, rom_addr = (vcount-ypos)*320 + (hcount-BANNER_X), range 0..21439. Otherwise rom_addr=0.
  - T+2: banner_pixel is valid. Registered copies of game_pixel, video_on and in_banner are aligned with it.
  - T+3: pixel_out is registered. If !video_on: 12'h000. Else if in_banner and banner_pixel != KEY_COLOR: banner_pixel. Else: game_pixel.
  - Total latency from input pixel to pixel_out is 3 cycles. Downstream sync is delayed to match outside this block.
- Rows with negative ypos coverage (partial banner above the screen) are clipped. Only rows >= 0 are addressed.
- State changes take effect on frame_tick only, except KO detection and restart, so a frame is never torn mid-banner.

Optional Feature:
- Macro: BANNER_BLINK_EN.
- When defined, in SHOW and WAIT finish[2] toggles every 30 frame_ticks, starting visible on SHOW entry. in_banner follows finish[2], so the banner blinks.
- When undefined, finish[2] stays steady at 1 in SHOW and WAIT.
- SLIDE behaviour is identical either way.

Test Plan:
- p2_health 50->0 in PLAY -> next cycle game_over=1, finish=3'b001.
- After 60 frame_ticks: SLIDE entered, finish=3'b101.
- Simultaneous p1_health=0, p2_health=0 -> finish[1]=0 (P1 wins). p1_health=0 alone -> finish[1]=1.
- SLIDE with SLIDE_STEP=4 -> ypos -67,-63,... and clamps at 206 after 69 ticks; then SHOW is entered.
- In SHOW with ypos=206, hcount=160, vcount=206 at T -> rom_addr=0 at T+1. hcount=479, vcount=272 -> rom_addr=21439. hcount=480 -> in_banner=0.
- banner_pixel=12'hF0F with game_pixel=12'h123 -> pixel_out=12'h123 at T+3. banner_pixel=12'hABC -> 12'hABC at T+3. video_on=0 -> 12'h000.
- start_btn pulsed in SHOW -> no response. Pulsed in WAIT -> restart_req high exactly 1 cycle, then PLAY with finish=0.
- rst_l=1 mid-SLIDE -> all outputs 0 next cycle and the FSM is in PLAY.
